enigma_stream_ctrl: RTL

ENIGMA_STREAM_CTRL -- requirements
Module: enigma_stream_ctrl

---
 rtl/enigma_stream_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/enigma_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : enigma_stream_ctrl
//  Purpose  : Bridges an ASCII valid/ready byte stream to a 5-bit enigma core.
//             Letters are converted to 0..25 codes and sent to the core with
//             a one-cycle pulse. After ENIGMA_LAT cycles the core result is
//             turned back into ASCII in the original case and queued in a
//             small output FIFO. Non-letters are dropped and counted. A
//             configuration request latches key and rotor settings and
//             strobes them into the core.
//  Ports    : clk, reset_n                   - clock, async active-low reset
//             s_valid/s_data/s_ready         - ASCII input stream
//             m_valid/m_data/m_ready         - ASCII output stream
//             cfg_start, key_in, rX_in       - configuration request/values
//             key, rX_cfg, load_key_cfg      - configuration to the core
//             char_in, new_char_pulse        - letter code to the core
//             enigma_char_out                - core result (0..25)
//             busy, drop_cnt                 - status
//  Revision : 1.0 - initial release
// ============================================================================
module enigma_stream_ctrl #(
  parameter int ENIGMA_LAT = 2,  // 1..15
  parameter int FIFO_DEPTH = 4   // power of two, >= 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [7:0]  m_data,
  input  logic        m_ready,
  input  logic        cfg_start,
  input  logic [14:0] key_in,
  input  logic [1:0]  rA_in,
  input  logic [1:0]  rB_in,
  input  logic [1:0]  rC_in,
  output logic [14:0] key,
  output logic [1:0]  rA_cfg,
  output logic [1:0]  rB_cfg,
  output logic [1:0]  rC_cfg,
  output logic        load_key_cfg,
  output logic [4:0]  char_in,
  output logic        new_char_pulse,
  input  logic [4:0]  enigma_char_out,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam int            c_AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_AW:0] c_DEPTH    = (c_AW + 1)'(FIFO_DEPTH);
  localparam logic [3:0]    c_LAT_LAST = 4'(ENIGMA_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t      r_state;
  logic [4:0]  r_code;
  logic        r_lower;
  logic [3:0]  r_wait_cnt;
  logic [7:0]  r_drop_cnt;
  logic [14:0] r_key;
  logic [1:0]  r_ra;
  logic [1:0]  r_rb;
  logic [1:0]  r_rc;
  logic        r_load;
  logic        r_pulse;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;

  logic       w_full;
  logic       w_empty;
  logic       w_s_ready;
  logic       w_accept;
  logic       w_is_upper;
  logic       w_is_lower;
  logic       w_push;
  logic       w_pop;
  logic [7:0] w_push_data;

  assign w_full    = (r_count == c_DEPTH);
  assign w_empty   = (r_count == '0);
  // Gated by reset_n so the port reads 0 while reset is held, even though
  // the state register already sits in IDLE.
  assign w_s_ready = reset_n && (r_state == ST_IDLE) && !w_full && !cfg_start;
  assign w_accept  = s_valid && w_s_ready;

  assign w_is_upper = (s_data >= 8'h41) && (s_data <= 8'h5A);
  assign w_is_lower = (s_data >= 8'h61) && (s_data <= 8'h7A);

  // The push fires at the edge that ends the last WAIT cycle. Only one
  // letter is ever in flight and acceptance needs a non-full FIFO, so a
  // push never meets a full FIFO.
  assign w_push = (r_state == ST_WAIT) && (r_wait_cnt == c_LAT_LAST);
  assign w_pop  = !w_empty && m_ready;

  always_comb begin
    w_push_data = 8'h3F;
    if (enigma_char_out <= 5'd25) begin
      w_push_data = (r_lower ? 8'h61 : 8'h41) + {3'b000, enigma_char_out};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_code     <= '0;
      r_lower    <= 1'b0;
      r_wait_cnt <= '0;
      r_drop_cnt <= '0;
      r_key      <= '0;
      r_ra       <= '0;
      r_rb       <= '0;
      r_rc       <= '0;
      r_load     <= 1'b0;
      r_pulse    <= 1'b0;
    end else begin
      r_load  <= 1'b0;
      r_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cfg_start) begin
            r_key   <= key_in;
            r_ra    <= rA_in;
            r_rb    <= rB_in;
            r_rc    <= rC_in;
            r_load  <= 1'b1;
            r_state <= ST_LOAD;
          end else if (w_accept) begin
            if (w_is_upper || w_is_lower) begin
              // 'A' (0x41) and 'a' (0x61) both have low bits 00001, so
              // the letter index is the low five bits minus one.
              r_code  <= s_data[4:0] - 5'd1;
              r_lower <= w_is_lower;
              r_pulse <= 1'b1;
              r_state <= ST_SEND;
            end else if (r_drop_cnt != 8'hFF) begin
              r_drop_cnt <= r_drop_cnt + 8'd1;
            end
          end
        end
        ST_LOAD: r_state <= ST_IDLE;
        ST_SEND: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_wait_cnt == c_LAT_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output FIFO; pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_AW + 1)'(1);
        2'b01:   r_count <= r_count - (c_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign s_ready        = w_s_ready;
  assign m_valid        = !w_empty;
  assign m_data         = r_mem[r_rd_ptr];
  assign key            = r_key;
  assign rA_cfg         = r_ra;
  assign rB_cfg         = r_rb;
  assign rC_cfg         = r_rc;
  assign load_key_cfg   = r_load;
  assign char_in        = r_code;
  assign new_char_pulse = r_pulse;
  assign busy           = (r_state != ST_IDLE);
  assign drop_cnt       = r_drop_cnt;

endmodule
`default_nettype wire
